// File: rtl/int_divider64b_pkg.sv
// Shared definitions for the 64-bit iterative integer divider:
// operation encodings, controller state encoding and the default width.
package int_divider64b_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // DIV and REM treat operands as two's complement.
    function automatic logic op_is_signed(input op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic op_is_rem(input op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: subtract the divisor from the shifted partial
// remainder and report whether the subtraction succeeded.
module div_sub_stage #(
    parameter int WIDTH = 65
) (
    input  logic [WIDTH-1:0] prem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             q_bit
);

    // The shifted remainder is always below twice the divisor, so the top bit
    // of the full-width difference is exactly the borrow of the subtraction.
    always_comb begin
        diff  = prem - divisor;
        q_bit = ~diff[WIDTH-1];
    end

endmodule

// File: rtl/int_divider64b.sv
// Iterative signed/unsigned integer divider. Operands are reduced to
// magnitudes, divided with one restoring shift-subtract step per cycle,
// then the signs are reapplied. Division by zero and signed overflow
// bypass the iteration and finish one cycle after the request.
module int_divider64b
    import int_divider64b_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                CNT_W     = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e state, state_nxt;

    // Captured operation. opa holds the raw dividend until PREP, then its
    // magnitude, which shifts out MSB-first while quotient bits shift in.
    op_e             op_q;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN:0]   prem;
    logic [CNT_W-1:0] cnt;
    logic            q_neg;
    logic            r_neg;

    logic            div_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   prem_shift;
    logic [XLEN:0]   sub_diff;
    logic            q_bit;
    logic [XLEN-1:0] quot_fixed;
    logic [XLEN-1:0] rem_fixed;

    // Special-case detection and the result those cases produce directly.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first so no path can infer a latch.
        special_result = '0;
        div_zero       = (opb == '0);
        sgn_ovf        = op_is_signed(op_q) && (opa == MOST_NEG) && (opb == '1);
        special        = div_zero || sgn_ovf;
        if (div_zero) begin
            special_result = op_is_rem(op_q) ? opa : '1;
        end else if (sgn_ovf) begin
            special_result = op_is_rem(op_q) ? '0 : opa;
        end
    end

    // Operand magnitudes for the unsigned core.
    always_comb begin
        mag_a = (op_is_signed(op_q) && opa[XLEN-1]) ? -opa : opa;
        mag_b = (op_is_signed(op_q) && opb[XLEN-1]) ? -opb : opb;
    end

    // Shift the next dividend bit into the partial remainder.
    always_comb begin
        prem_shift = (prem << 1) | {{XLEN{1'b0}}, opa[XLEN-1]};
    end

    div_sub_stage #(
        .WIDTH (XLEN + 1)
    ) u_sub_stage (
        .prem    (prem_shift),
        .divisor ({1'b0, opb}),
        .diff    (sub_diff),
        .q_bit   (q_bit)
    );

    // Sign correction: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        quot_fixed = q_neg ? -opa : opa;
        rem_fixed  = r_neg ? -prem[XLEN-1:0] : prem[XLEN-1:0];
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PREP;
            S_PREP: state_nxt = special ? S_DONE : S_ITER;
            S_ITER: if (cnt == LAST_STEP) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Controller outputs decoded from the current state.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath: capture, prepare magnitudes, iterate, and load the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are cleared too, so an aborted operation leaves nothing behind for the next one.
            op_q   <= OP_DIV;
            opa    <= '0;
            opb    <= '0;
            prem   <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op_e'(op);
                        opa  <= a;
                        opb  <= b;
                    end
                end
                S_PREP: begin
                    if (special) begin
                        result <= special_result;
                    end else begin
                        opa   <= mag_a;
                        opb   <= mag_b;
                        prem  <= '0;
                        cnt   <= '0;
                        q_neg <= op_is_signed(op_q) && (opa[XLEN-1] ^ opb[XLEN-1]);
                        r_neg <= op_is_signed(op_q) && opa[XLEN-1];
                    end
                end
                S_ITER: begin
                    prem <= q_bit ? sub_diff : prem_shift;
                    opa  <= {opa[XLEN-2:0], q_bit};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    result <= op_is_rem(op_q) ? rem_fixed : quot_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_divider64b.sv
// Self-checking bench for int_divider64b: a cycle-level reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_int_divider64b;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [1:0]  DIV  = 2'b00;
    localparam logic [1:0]  DIVU = 2'b01;
    localparam logic [1:0]  REM  = 2'b10;
    localparam logic [1:0]  REMU = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    int_divider64b #(.XLEN(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [63:0] exp_value(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        longint sx;
        longint sy;
        sx = x;
        sy = y;
        if (y == 64'd0) return o[1] ? x : ONES;
        if (!o[0] && x == MIN && y == ONES) return o[1] ? 64'd0 : x;
        case (o)
            DIV:     return 64'(sx / sy);
            DIVU:    return x / y;
            REM:     return 64'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        if (y == 64'd0) return 1;
        if (!o[0] && x == MIN && y == ONES) return 1;
        return 66;
    endfunction

    // Cycle-level model: accept in idle, count down the latency, one done cycle.
    bit          m_active  = 1'b0;
    bit          m_done    = 1'b0;
    int          m_left    = 0;
    logic [63:0] m_result  = '0;
    logic [63:0] m_pending = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_left   = 0;
            m_result = '0;
        end else if (m_done) begin
            m_done   = 1'b0;
            m_active = 1'b0;
        end else if (m_active) begin
            m_left--;
            if (m_left == 0) begin
                m_done   = 1'b1;
                m_result = m_pending;
            end
        end else if (start) begin
            m_active  = 1'b1;
            m_pending = exp_value(op, a, b);
            m_left    = exp_latency(op, a, b);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_busy", 64'(busy), 64'(m_active));
        check("cyc_done", 64'(done), 64'(m_done));
        check("cyc_result", result, m_result);
    end

    // Wait (bounded) for done; elapsed counts edges since the accepting edge.
    task automatic wait_done(output int elapsed);
        elapsed = 0;
        do begin
            @(negedge clk);
            elapsed++;
        end while (!done && elapsed < 100);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] lit, input int lat);
        int elapsed;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        wait_done(elapsed);
        check({name, "_lat"}, 64'(elapsed), 64'(lat));
        check({name, "_res"}, result, lit);
        check({name, "_model"}, exp_value(o, x, y), lit);
    endtask

    initial begin
        int elapsed;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        rst_n = 1'b1;

        run_op("div_m7_2",   DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem_m7_2",   REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
        run_op("rem_7_m2",   REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66);
        run_op("divu_z",     DIVU, 64'h1234, 64'd0, ONES, 1);
        run_op("remu_z",     REMU, 64'h1234, 64'd0, 64'h1234, 1);
        run_op("rem_z",      REM,  64'hFFFF_FFFF_FFFF_FF00, 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 1);
        run_op("div_ovf",    DIV,  MIN, ONES, MIN, 1);
        run_op("rem_ovf",    REM,  MIN, ONES, 64'd0, 1);
        run_op("divu_min",   DIVU, MIN, ONES, 64'd0, 66);
        run_op("remu_min",   REMU, MIN, ONES, MIN, 66);
        run_op("div_m100_m7", DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 66);
        run_op("rem_m100_m7", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("div_100_m7", DIV,  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 66);
        run_op("rem_m14_7",  REM,  64'hFFFF_FFFF_FFFF_FFF2, 64'd7, 64'd0, 66);
        run_op("divu_big",   DIVU, ONES, 64'h1_0000_0000, 64'hFFFF_FFFF, 66);
        run_op("remu_big",   REMU, ONES, 64'h1_0000_0000, 64'hFFFF_FFFF, 66);
        run_op("divu_by1",   DIVU, ONES, 64'd1, ONES, 66);
        run_op("div_m7_2b",  DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        op    = DIVU;
        a     = 64'd100;
        b     = 64'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("remu_after_rst", REMU, 64'd100, 64'd7, 64'd2, 66);

        // start held high: second request accepted only once back in idle.
        @(negedge clk);
        start = 1'b1;
        op    = DIVU;
        a     = 64'd1000;
        b     = 64'd10;
        @(posedge clk);
        @(negedge clk);
        wait_done(elapsed);
        check("held_lat1", 64'(elapsed), 64'd66);
        check("held_res1", result, 64'd100);
        @(negedge clk);
        check("held_gap_busy", 64'(busy), 64'd0);
        check("held_gap_result", result, 64'd100);
        @(negedge clk);
        check("held_accept_busy", 64'(busy), 64'd1);
        check("held_accept_result", result, 64'd100);
        start = 1'b0;
        wait_done(elapsed);
        check("held_lat2", 64'(elapsed), 64'd66);
        check("held_res2", result, 64'd100);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_divider64b.md
INT_DIVIDER64B -- requirements
Module: int_divider64b

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width; all cycle counts below assume XLEN=64 and scale as XLEN+2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port a  input  XLEN  dividend.
REQ-007 SHALL have port b  input  XLEN  divisor.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  XLEN  quotient or remainder per op.

Function
REQ-011 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
REQ-012 On the edge E0 where start=1 in IDLE: SHALL capture op, a, b and go to PREP; start in any other state SHALL be ignored.
REQ-013 PREP (edge E0+1): SHALL compute magnitudes for signed ops and detect special cases; special case goes directly to DONE with the final result loaded, else go to ITER.
REQ-014 ITER: SHALL perform one restoring shift-subtract step per cycle, exactly 64 steps (edges E0+2..E0+65), 7-bit counter; the last step goes to FIX.
REQ-015 FIX (edge E0+66): SHALL apply signs and load result, then go to DONE.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE on the next edge; done rises at E0+66 for normal ops and E0+1 for special cases.
REQ-017 Signed quotient SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign; a zero remainder stays zero.
REQ-018 Divide by zero: quotient SHALL be all ones (DIV and DIVU), and remainder SHALL equal a (REM and REMU).
REQ-019 Signed overflow (a=0x8000_0000_0000_0000, b=all ones, DIV/REM only): quotient SHALL be a, remainder SHALL be 0.
REQ-020 result SHALL hold its value from done until the next result load; the input operands may change freely after E0.
REQ-021 The internal partial remainder SHALL be 65 bits so that the subtract borrow is explicit; no intermediate truncation.

Reset
REQ-022 rst_n low SHALL force IDLE, busy=0, done=0, result=0, and clear the counter and datapath registers, immediately and asynchronously, including mid-operation.
REQ-023 After rst_n rises, the first start SHALL follow REQ-012 with no residue from an aborted operation.

Structure
REQ-024 A shared ALU package SHALL hold the op encodings, the state encoding, and the XLEN default.
REQ-025 One sub-module div_sub_stage SHALL implement the 65-bit conditional subtract: inputs are the partial remainder and divisor; outputs are the difference and the quotient bit (no borrow = 1).

Verification
REQ-026 DIV a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3), done at E0+66, busy high E0..E0+66.
REQ-027 REM a=-7, b=2 -> result 0xFFFF_FFFF_FFFF_FFFF (-1); REM a=7, b=-2 -> result 1.
REQ-028 DIVU a=0x1234, b=0 -> result all ones at E0+1; REMU same operands -> result 0x1234 at E0+1.
REQ-029 DIV a=0x8000_0000_0000_0000, b=all ones -> result 0x8000_0000_0000_0000 at E0+1; REM same operands -> result 0.
REQ-030 DIVU 100/7 started, rst_n pulsed low at E0+30 -> busy, done, and result all 0 at once; restarted REMU 100/7 -> result 2 at new E0+66.
REQ-031 start held high throughout an operation -> the second request is accepted only at the first IDLE edge after done; result stays stable between done and that acceptance.
